dac_ctl: RTL and testbench
==========================

// Module: dac_ctl
// PURPOSE
//  SPI write controller for the 16-bit OCXO tuning DAC (AD5541A-type, write-only).
//  Sits downstream of the GPIO/IO block and consumes its dac_ena and dac_tri (OCXO power-good) outputs.
//  Accepts tuning words over a valid/ready handshake and serialises them MSB first.
//  Restores the last written word whenever the DAC pins come out of tristate.
// PARAMETERS
//  DATA_W   16  DAC word width, in bits
//  CLK_DIV  2   length of each SCLK phase, in clk cycles (>=1)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       reset, asynchronous, active-low
//  dac_ena    in   1       controller enable (from io, clk domain)
//  dac_tri    in   1       1 = DAC pins tristated, OCXO not yet powered (from io)
//  val_valid  in   1       tuning word valid
//  val_data   in   DATA_W  tuning word
//  val_ready  out  1       controller can accept a word
//  last_data  out  DATA_W  last accepted word
//  busy       out  1       frame in progress
//  dac_cs_n   out  1       SPI chip select
//  dac_sclk   out  1       SPI clock
//  dac_sdi    out  1       SPI data
//  dac_ldac_n out  1       DAC load strobe
//  dac_t      out  1       pad tristate control, 1 = Z
// BEHAVIOUR
//  Reset values:
//   - val_ready=0, busy=0, last_data=0, dac_cs_n=1, dac_sclk=0, dac_sdi=0, dac_ldac_n=1(LDAC_EN)/0, dac_t=1
//   - restore_pend=0, have_data=0
//  dac_t is dac_tri registered, 1 cycle latency.
//  States: IDLE -> SETUP -> SHIFT -> GAP [-> LDAC] -> IDLE.
//  drive_ok = dac_ena & ~dac_tri.
//  val_ready = (state==IDLE) & drive_ok & ~restore_pend.
//  Word is accepted on the edge where val_valid & val_ready; it also loads last_data and sets have_data.
//  A valid that is not accepted must be held by the source; there is no buffering.
//  IDLE:
//   - If restore_pend & drive_ok: start a frame with last_data and clear restore_pend.
//   - Restore takes priority over a new word.
//  SETUP (CLK_DIV cycles):
//   - Starts the cycle after acceptance.
//   - cs_n=0, sclk=0, sdi=MSB.
//  SHIFT, for each of DATA_W bits:
//   - sclk=1 for CLK_DIV cycles, then sclk=0 for CLK_DIV cycles.
//   - sdi advances to the next bit at the 1->0 transition; the DAC samples on the rising edge.
//   - After the last low phase: cs_n=1, sdi=0.
//   - cs_n is low for CLK_DIV*(2*DATA_W+1) cycles in total.
//  GAP: cs_n=1 for CLK_DIV cycles, then go to LDAC (if built) or IDLE.
//  busy = (state != IDLE).
//  Counters: phase counter sized $clog2(CLK_DIV+1); bit counter sized $clog2(DATA_W+1); no wrap beyond terminal value.
//  Abort:
//   - Trigger: drive_ok goes 0 in any non-IDLE state.
//   - Next cycle: cs_n=1, sclk=0, sdi=0, ldac_n idle, state=IDLE.
//   - Set restore_pend if have_data.
//  Rising drive_ok (dac_tri 1->0 while dac_ena=1, or dac_ena 0->1 while dac_tri=0): set restore_pend if have_data.
//  Simultaneous accept and drive_ok fall: impossible, because ready requires drive_ok in the same cycle.
//  Async reset mid-frame: all outputs go to their reset values immediately; the frame is lost and no restore follows.
// CONFIGURATION
//  DAC_LDAC_EN defined:
//   - After GAP, dac_ldac_n=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles, then IDLE.
//   - Abort during LDAC forces dac_ldac_n=1.
//  DAC_LDAC_EN undefined:
//   - dac_ldac_n is constant 0 (DAC updates on the cs_n rising edge).
//   - No LDAC state is generated.
// STRUCTURE
//  Shared clock_pkg holds:
//   - typedef enum logic [2:0] dac_state_t {DAC_IDLE, DAC_SETUP, DAC_SHIFT, DAC_GAP, DAC_LDAC}
//   - localparam DAC_W_DEF = 16
//  Natural sub-module: spi_tx_shift (parallel-load shift register plus SCLK phase generator, abortable).
//  Handshake, restore logic and FSM stay in dac_ctl.
// TESTING (DATA_W=16, CLK_DIV=2)
//  1. dac_ena=1, dac_tri=0, write 0xA5C3:
//     - cs_n low 66 cycles; 16 sclk rising edges; sampled bits = 0xA5C3.
//     - val_ready returns 2 cycles after cs_n rises (no LDAC_EN).
//  2. dac_tri=1, val_valid=1:
//     - val_ready=0, dac_t=1 one cycle later, cs_n stays 1, last_data unchanged.
//  3. Write 0x1234, drop dac_ena after the 5th sclk rising edge:
//     - Next cycle cs_n=1, sclk=0, state IDLE.
//     - Raising dac_ena again resends the full 0x1234 frame without val_valid.
//  4. Write 0x8000, then dac_tri 0->1->0:
//     - No frames while tristated.
//     - After release, exactly one automatic frame carrying 0x8000; val_ready low until it completes.
//  5. val_valid held with 0x0001 then 0xFFFF back-to-back:
//     - Two frames; the second cs_n falls >=2 cycles after the first rises; last_data=0xFFFF.
//  6. DAC_LDAC_EN defined: ldac_n low exactly 2 cycles, starting 2 cycles after cs_n rises.
//     DAC_LDAC_EN undefined: ldac_n constant 0.
//     Async reset pulse mid-SHIFT: outputs at reset values immediately.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared clocking-subsystem definitions: DAC controller state encoding and default word width.
package clock_pkg;

   // Frame sequencer states for the OCXO tuning DAC controller.
   typedef enum logic [2:0] {
      DAC_IDLE,
      DAC_SETUP,
      DAC_SHIFT,
      DAC_GAP,
      DAC_LDAC
   } dac_state_t;

   localparam int unsigned DAC_W_DEF = 16;

endpackage

// File: rtl/dac_ctl_spi_tx.sv
// spi_tx_shift: parallel-load shift register plus SCLK phase generator for one SPI write frame.
// The phase timing (when to toggle) comes from the parent as single-cycle strobes; this block
// owns the data/clock pins and the bit count, and can be cleared at any point (end or abort).
module spi_tx_shift
   import clock_pkg::*;
#(
   parameter int unsigned DATA_W = DAC_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,   // capture data, SCLK low, MSB on SDI
   input  logic [DATA_W-1:0] data,
   input  logic              start,  // end of setup phase: first SCLK rise
   input  logic              step,   // end of an SCLK phase: toggle, shift on the fall
   input  logic              clear,  // end of frame or abort: pins back to idle
   output logic              sclk,
   output logic              sdi,
   output logic              done    // all bits clocked out, in the final low phase
);

   localparam int unsigned BIT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] sh_q;
   logic              sclk_q;
   logic              act_q;
   logic [BIT_W-1:0]  bit_q;

   // Shift register, SCLK level and bit counter; clear wins over any coincident step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q   <= '0;
         sclk_q <= 1'b0;
         act_q  <= 1'b0;
         bit_q  <= '0;
      end else if (load) begin
         sh_q   <= data;
         sclk_q <= 1'b0;
         act_q  <= 1'b1;
         bit_q  <= '0;
      end else if (clear) begin
         sh_q   <= '0;
         sclk_q <= 1'b0;
         act_q  <= 1'b0;
         bit_q  <= '0;
      end else if (start) begin
         sclk_q <= 1'b1;
      end else if (step) begin
         if (sclk_q) begin
            // Falling edge: present the next bit; the DAC sampled the current one on the rise.
            sclk_q <= 1'b0;
            sh_q   <= {sh_q[DATA_W-2:0], 1'b0};
            if (bit_q != BIT_W'(DATA_W)) begin
               bit_q <= bit_q + BIT_W'(1);
            end
         end else begin
            sclk_q <= 1'b1;
         end
      end
   end

   // Pin and status decode from the registered state.
   always_comb begin
      sclk = sclk_q;
      sdi  = act_q & sh_q[DATA_W-1];
      done = (bit_q == BIT_W'(DATA_W));
   end

endmodule

// File: rtl/dac_ctl.sv
// dac_ctl: SPI write controller for the 16-bit OCXO tuning DAC (write-only, MSB first).
// Accepts tuning words on a valid/ready handshake and replays the last word whenever the DAC
// pins come back from tristate or a frame was cut short.
// Build option: define DAC_LDAC_EN to drive an LDAC strobe after each frame; otherwise
// dac_ldac_n is tied low and the DAC updates on the chip-select rising edge.
module dac_ctl
   import clock_pkg::*;
#(
   parameter int unsigned DATA_W  = DAC_W_DEF,
   parameter int unsigned CLK_DIV = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dac_ena,
   input  logic              dac_tri,
   input  logic              val_valid,
   input  logic [DATA_W-1:0] val_data,
   output logic              val_ready,
   output logic [DATA_W-1:0] last_data,
   output logic              busy,
   output logic              dac_cs_n,
   output logic              dac_sclk,
   output logic              dac_sdi,
   output logic              dac_ldac_n,
   output logic              dac_t
);

   localparam int unsigned PH_W = $clog2(CLK_DIV + 1);

   dac_state_t        state_q, state_d;
   logic [PH_W-1:0]   phase_q;
   logic              phase_end;
   logic              run_q;
   logic              dac_t_q;
   logic              cs_n_q, cs_n_d;
   logic              restore_pend_q;
   logic              have_data_q;
   logic [DATA_W-1:0] last_data_q;

   logic              drive_ok;
   logic              accept;
   logic              start_restore;
   logic              abort;
   logic              sh_load, sh_start, sh_step, sh_clear, sh_done;
   logic [DATA_W-1:0] sh_data;

`ifdef DAC_LDAC_EN
   logic              half_q, half_d;
   logic              ldac_n_q, ldac_n_d;
`endif

   // Handshake and frame-start decode; run_q keeps ready low while in reset.
   always_comb begin
      drive_ok      = dac_ena & ~dac_tri;
      val_ready     = run_q & (state_q == DAC_IDLE) & drive_ok & ~restore_pend_q;
      accept        = val_valid & val_ready;
      start_restore = run_q & (state_q == DAC_IDLE) & drive_ok & restore_pend_q;
      abort         = (state_q != DAC_IDLE) & ~drive_ok;
      phase_end     = (phase_q == PH_W'(CLK_DIV - 1));
      sh_data       = start_restore ? last_data_q : val_data;
   end

   // Next-state and shift-register control.
   always_comb begin
      state_d  = state_q;
      sh_load  = 1'b0;
      sh_start = 1'b0;
      sh_step  = 1'b0;
      sh_clear = 1'b0;
      if (abort) begin
         state_d  = DAC_IDLE;
         sh_clear = 1'b1;
      end else begin
         unique case (state_q)
            DAC_IDLE: begin
               if (start_restore || accept) begin
                  state_d = DAC_SETUP;
                  sh_load = 1'b1;
               end
            end
            DAC_SETUP: begin
               if (phase_end) begin
                  state_d  = DAC_SHIFT;
                  sh_start = 1'b1;
               end
            end
            DAC_SHIFT: begin
               if (phase_end) begin
                  if (sh_done) begin
                     state_d  = DAC_GAP;
                     sh_clear = 1'b1;
                  end else begin
                     sh_step = 1'b1;
                  end
               end
            end
            DAC_GAP: begin
               if (phase_end) begin
`ifdef DAC_LDAC_EN
                  state_d = DAC_LDAC;
`else
                  state_d = DAC_IDLE;
`endif
               end
            end
`ifdef DAC_LDAC_EN
            DAC_LDAC: begin
               if (phase_end && half_q) begin
                  state_d = DAC_IDLE;
               end
            end
`endif
            default: state_d = DAC_IDLE;
         endcase
      end
      cs_n_d = ~((state_d == DAC_SETUP) || (state_d == DAC_SHIFT));
   end

`ifdef DAC_LDAC_EN
   // LDAC: low for the first phase, high for the second; any exit from LDAC releases it.
   always_comb begin
      half_d   = (state_q == DAC_LDAC) ? (half_q | phase_end) : 1'b0;
      ldac_n_d = ~((state_d == DAC_LDAC) && !half_d);
   end

   // LDAC phase flag and strobe register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_q   <= 1'b0;
         ldac_n_q <= 1'b1;
      end else begin
         half_q   <= half_d;
         ldac_n_q <= ldac_n_d;
      end
   end

   assign dac_ldac_n = ldac_n_q;
`else
   assign dac_ldac_n = 1'b0;
`endif

   // State, chip select, pad tristate and run flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DAC_IDLE;
         cs_n_q  <= 1'b1;
         dac_t_q <= 1'b1;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cs_n_q  <= cs_n_d;
         dac_t_q <= dac_tri;
         run_q   <= 1'b1;
      end
   end

   // Phase counter: restarts on every state change and at each phase boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
      end else if ((state_q == DAC_IDLE) || (state_d != state_q) || phase_end) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_q + PH_W'(1);
      end
   end

   // Last word, and the replay request owed whenever the pins were not drivable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_data_q    <= '0;
         have_data_q    <= 1'b0;
         restore_pend_q <= 1'b0;
      end else begin
         if (accept) begin
            last_data_q <= val_data;
            have_data_q <= 1'b1;
         end
         // Requesting while undrivable makes the replay start on the first drivable cycle.
         if (start_restore) begin
            restore_pend_q <= 1'b0;
         end else if (!drive_ok && have_data_q) begin
            restore_pend_q <= 1'b1;
         end
      end
   end

   spi_tx_shift #(
      .DATA_W (DATA_W)
   ) u_spi_tx_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (sh_load),
      .data  (sh_data),
      .start (sh_start),
      .step  (sh_step),
      .clear (sh_clear),
      .sclk  (dac_sclk),
      .sdi   (dac_sdi),
      .done  (sh_done)
   );

   assign last_data = last_data_q;
   assign busy      = (state_q != DAC_IDLE);
   assign dac_cs_n  = cs_n_q;
   assign dac_t     = dac_t_q;

endmodule

// File: tb/tb_dac_ctl.sv
// Bench for dac_ctl: SPI frames are decoded from the pins and scored against a queue of words
// the handshake and replay rules say must appear.
module tb_dac_ctl;

   localparam int DW        = 16;
   localparam int CD        = 2;
   localparam int FRAME_LEN = CD * (2 * DW + 1);
`ifdef DAC_LDAC_EN
   localparam int READY_GAP = 3 * CD;
   localparam logic LDAC_RST = 1'b1;
`else
   localparam int READY_GAP = CD;
   localparam logic LDAC_RST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          dac_ena = 1'b1;
   logic          dac_tri = 1'b0;
   logic          val_valid = 1'b0;
   logic [DW-1:0] val_data = '0;
   logic          val_ready;
   logic [DW-1:0] last_data;
   logic          busy, dac_cs_n, dac_sclk, dac_sdi, dac_ldac_n, dac_t;

   dac_ctl #(
      .DATA_W  (DW),
      .CLK_DIV (CD)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dac_ena    (dac_ena),
      .dac_tri    (dac_tri),
      .val_valid  (val_valid),
      .val_data   (val_data),
      .val_ready  (val_ready),
      .last_data  (last_data),
      .busy       (busy),
      .dac_cs_n   (dac_cs_n),
      .dac_sclk   (dac_sclk),
      .dac_sdi    (dac_sdi),
      .dac_ldac_n (dac_ldac_n),
      .dac_t      (dac_t)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] word;
      int          bits;
      int          len;
      int          gap;
   } frame_t;

   frame_t rx_q[$];
   int     exp_q[$];
   int     n_chk = 0;
   int     n_pass = 0;
   int     cyc = 0;
   int     frames_started = 0;
   int     last_rise = -1000;
   int     ready_busy_bad = 0;
   int     ldac_fall = 0;
   int     ldac_len = 0;
   int     ldac_hi = 0;
   logic [DW-1:0] m_last = '0;
   bit     m_have = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Pin-level frame decoder.
   initial begin : monitor
      logic [31:0] cur_w;
      int   cur_bits, cur_len, cur_gap;
      logic prev_cs, prev_sclk, prev_ldac;
      frame_t f;
      cur_w = 0; cur_bits = 0; cur_len = 0; cur_gap = 0;
      prev_cs = 1'b1; prev_sclk = 1'b0; prev_ldac = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_cs = 1'b1;
            prev_sclk = 1'b0;
         end else begin
            if (prev_cs && !dac_cs_n) begin
               cur_w = 0; cur_bits = 0; cur_len = 0;
               cur_gap = cyc - last_rise;
               frames_started++;
            end
            if (!dac_cs_n) begin
               cur_len++;
               if (dac_sclk && !prev_sclk) begin
                  cur_w = {cur_w[30:0], dac_sdi};
                  cur_bits++;
               end
            end
            if (!prev_cs && dac_cs_n) begin
               f.word = cur_w; f.bits = cur_bits; f.len = cur_len; f.gap = cur_gap;
               rx_q.push_back(f);
               last_rise = cyc;
            end
`ifdef DAC_LDAC_EN
            if (prev_ldac && !dac_ldac_n) begin
               ldac_fall = cyc;
               ldac_len = 0;
            end
            if (!dac_ldac_n) ldac_len++;
`else
            if (dac_ldac_n) ldac_hi++;
`endif
            if (val_ready && busy) ready_busy_bad++;
            prev_cs = dac_cs_n;
            prev_sclk = dac_sclk;
            prev_ldac = dac_ldac_n;
         end
      end
   end

   task automatic write_word(input logic [DW-1:0] w);
      int n = 0;
      @(negedge clk);
      val_valid = 1'b1;
      val_data = w;
      while (!val_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("write timeout", 0, 1);
      @(posedge clk);
      #1 val_valid = 1'b0;
      m_last = w;
      m_have = 1'b1;
      exp_q.push_back(int'(w));
      @(negedge clk);
      chk("last_data", last_data, w);
   endtask

   task automatic wait_idle();
      int n = 0;
      repeat (3) @(negedge clk);
      while ((busy || !dac_cs_n) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk("idle timeout", 0, 1);
      @(negedge clk);
   endtask

   // Wait for k SCLK rises, then make the pins undrivable (mode 0: ena low, 1: tri high).
   task automatic abort_after(input int k, input int mode);
      int   cnt = 0;
      int   n = 0;
      logic prev = 1'b0;
      while (cnt < k && n < 400) begin
         @(negedge clk);
         n++;
         if (dac_sclk && !prev) cnt++;
         prev = dac_sclk;
      end
      if (n >= 400) chk("sclk timeout", 0, 1);
      if (mode == 0) dac_ena = 1'b0;
      else if (mode == 1) dac_tri = 1'b1;
   endtask

   task automatic check_abort_and_release(input string tag, input int hold);
      int fs;
      @(negedge clk);
      chk({tag, " cs_n"}, dac_cs_n, 1);
      chk({tag, " sclk"}, dac_sclk, 0);
      chk({tag, " idle"}, busy, 0);
      fs = frames_started;
      repeat (hold) @(negedge clk);
      chk({tag, " no frame while off"}, frames_started - fs, 0);
      dac_ena = 1'b1;
      dac_tri = 1'b0;
      // Replace the cut frame's entry by an abort marker, then expect the replay.
      void'(exp_q.pop_back());
      exp_q.push_back(-1);
      exp_q.push_back(int'(m_last));
      wait_idle();
   endtask

   task automatic drain(input string tag);
      frame_t f;
      int     e;
      chk({tag, " nframes"}, rx_q.size(), exp_q.size());
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         f = rx_q.pop_front();
         e = exp_q.pop_front();
         if (e < 0) begin
            chk({tag, " cut short"}, (f.bits < DW) ? 1 : 0, 1);
         end else begin
            chk({tag, " word"}, f.word, e);
            chk({tag, " bits"}, f.bits, DW);
            chk({tag, " cs_len"}, f.len, FRAME_LEN);
         end
      end
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin : main
      int fs, n, r, hold, mode;
      frame_t f;
      logic [DW-1:0] w;

      // Reset state.
      #23;
      chk("rst val_ready", val_ready, 0);
      chk("rst busy", busy, 0);
      chk("rst last_data", last_data, 0);
      chk("rst cs_n", dac_cs_n, 1);
      chk("rst sclk", dac_sclk, 0);
      chk("rst sdi", dac_sdi, 0);
      chk("rst ldac_n", dac_ldac_n, LDAC_RST);
      chk("rst dac_t", dac_t, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("dac_t follows", dac_t, 0);

      // Tristated: no acceptance, no frame, and with no data yet nothing replays on release.
      dac_tri = 1'b1;
      val_valid = 1'b1;
      val_data = 16'h5555;
      fs = frames_started;
      @(negedge clk);
      chk("t2 dac_t", dac_t, 1);
      chk("t2 ready", val_ready, 0);
      repeat (10) @(negedge clk);
      chk("t2 frames", frames_started - fs, 0);
      chk("t2 last_data", last_data, 0);
      val_valid = 1'b0;
      dac_tri = 1'b0;
      repeat (10) @(negedge clk);
      chk("t2 no replay", frames_started - fs, 0);

      // Single write: framing and handshake turnaround.
      write_word(16'hA5C3);
      n = 0;
      while (!val_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("t1 ready gap", cyc - last_rise, READY_GAP);
`ifdef DAC_LDAC_EN
      chk("t1 ldac start", ldac_fall - last_rise, CD);
      chk("t1 ldac len", ldac_len, CD);
`endif
      drain("t1");

      // Abort after the 5th SCLK rise by dropping enable, then replay on re-enable.
      write_word(16'h1234);
      abort_after(5, 0);
      check_abort_and_release("t3", 8);
      drain("t3");

      // Tristate bounce after a write: exactly one replay, ready held low through it.
      write_word(16'h8000);
      wait_idle();
      drain("t4 write");
      fs = frames_started;
      ready_busy_bad = 0;
      dac_tri = 1'b1;
      repeat (20) @(negedge clk);
      chk("t4 no frame tri", frames_started - fs, 0);
      dac_tri = 1'b0;
      exp_q.push_back(int'(m_last));
      wait_idle();
      repeat (20) @(negedge clk);
      chk("t4 one replay", frames_started - fs, 1);
      chk("t4 ready while busy", ready_busy_bad, 0);
      drain("t4");

      // Back-to-back writes with valid held.
      @(negedge clk);
      val_valid = 1'b1;
      val_data = 16'h0001;
      n = 0;
      while (!val_ready && n < 300) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 val_data = 16'hFFFF;
      @(negedge clk);
      n = 0;
      while (!val_ready && n < 300) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 val_valid = 1'b0;
      m_last = 16'hFFFF;
      exp_q.push_back(32'h0001);
      exp_q.push_back(32'hFFFF);
      wait_idle();
      chk("t5 last_data", last_data, 16'hFFFF);
      if (rx_q.size() == 2) begin
         f = rx_q[1];
         chk("t5 inter-frame gap", (f.gap >= 2) ? 1 : 0, 1);
      end
      drain("t5");

      // Randomized mix of writes, idle bounces and mid-frame aborts.
      for (int i = 0; i < 14; i++) begin
         r = $urandom_range(0, 3);
         w = DW'($urandom);
         mode = $urandom_range(0, 1);
         hold = $urandom_range(3, 20);
         if (r <= 1) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            write_word(w);
            wait_idle();
         end else if (r == 2) begin
            if (mode == 0) dac_ena = 1'b0;
            else dac_tri = 1'b1;
            repeat (hold) @(negedge clk);
            dac_ena = 1'b1;
            dac_tri = 1'b0;
            if (m_have) exp_q.push_back(int'(m_last));
            wait_idle();
         end else begin
            write_word(w);
            abort_after($urandom_range(1, DW - 1), mode);
            check_abort_and_release("rnd abort", hold);
         end
         drain("rnd");
      end

`ifndef DAC_LDAC_EN
      chk("ldac_n held low", ldac_hi, 0);
`endif

      // Asynchronous reset in the middle of a shift: immediate reset values, no replay.
      write_word(16'h5A5A);
      abort_after(3, 2);
      #3 rst_n = 1'b0;
      #1;
      fs = frames_started;
      chk("arst val_ready", val_ready, 0);
      chk("arst busy", busy, 0);
      chk("arst last_data", last_data, 0);
      chk("arst cs_n", dac_cs_n, 1);
      chk("arst sclk", dac_sclk, 0);
      chk("arst sdi", dac_sdi, 0);
      chk("arst ldac_n", dac_ldac_n, LDAC_RST);
      chk("arst dac_t", dac_t, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      chk("arst no replay", frames_started - fs, 0);
      chk("arst idle", busy, 0);
      chk("arst ready", val_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
